// File: rtl/stream_checksum_append_if.sv
// Byte stream handshake bundle: valid/ready transfer of 8-bit data with a last marker.
// The master drives valid/last/data, the slave drives ready.
interface stream_checksum_append_if;
  logic       valid;
  logic       ready;
  logic       last;
  logic [7:0] data;

  modport master (
    output valid,
    output last,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    output ready
  );
endinterface

// File: rtl/stream_checksum_append.sv
// Forwards packet bytes through a registered output and appends a two's-complement
// checksum trailer after each packet; counts trailers delivered downstream.
module stream_checksum_append #(
  parameter logic [7:0] CHECKSUM_INIT = 8'h00,
  parameter int         CNT_WIDTH     = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  stream_checksum_append_if.slave    sink,
  stream_checksum_append_if.master   source,
  output logic [CNT_WIDTH-1:0]       pkt_count
);

  typedef enum logic [0:0] {
    ST_DATA = 1'b0,
    ST_CSUM = 1'b1
  } state_t;

  function automatic logic [7:0] csum_negate(input logic [7:0] acc);
    return (~acc) + 8'd1;
  endfunction

  state_t               state_r;
  state_t               state_nx;
  logic [7:0]           sum_r;
  logic [7:0]           sum_nx;
  logic                 valid_r;
  logic                 valid_nx;
  logic                 last_r;
  logic                 last_nx;
  logic [7:0]           data_r;
  logic [7:0]           data_nx;
  logic [CNT_WIDTH-1:0] pkt_count_r;
  logic [CNT_WIDTH-1:0] pkt_count_nx;

  logic                 load_s;
  logic                 sink_ready_s;
  logic                 sink_xfer_s;
  logic                 trailer_xfer_s;

  // The output register is free when empty or being drained this cycle.
  assign load_s         = !valid_r || source.ready;
  assign sink_ready_s   = (state_r == ST_DATA) && load_s;
  assign sink_xfer_s    = sink.valid && sink_ready_s;
  assign trailer_xfer_s = valid_r && source.ready && last_r;

  assign sink.ready   = sink_ready_s;
  assign source.valid = valid_r;
  assign source.last  = last_r;
  assign source.data  = data_r;
  assign pkt_count    = pkt_count_r;

  // Next-state and datapath update for the data/trailer sequencing.
  always_comb begin
    state_nx = state_r;
    sum_nx   = sum_r;
    valid_nx = valid_r;
    last_nx  = last_r;
    data_nx  = data_r;
    case (state_r)
      ST_DATA: begin
        if (sink_xfer_s) begin
          data_nx  = sink.data;
          last_nx  = 1'b0;
          valid_nx = 1'b1;
          sum_nx   = sum_r + sink.data;
          if (sink.last) begin
            state_nx = ST_CSUM;
          end else begin
            state_nx = ST_DATA;
          end
        end else if (source.ready) begin
          valid_nx = 1'b0;
        end else begin
          valid_nx = valid_r;
        end
      end
      ST_CSUM: begin
        // sum already holds the final data byte, so the trailer is ready to load.
        if (load_s) begin
          data_nx  = csum_negate(sum_r);
          last_nx  = 1'b1;
          valid_nx = 1'b1;
          sum_nx   = CHECKSUM_INIT;
          state_nx = ST_DATA;
        end else begin
          state_nx = ST_CSUM;
        end
      end
      default: begin
        state_nx = ST_DATA;
        sum_nx   = CHECKSUM_INIT;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        data_nx  = 8'h00;
      end
    endcase
  end

  // Packet counter advances when a trailer leaves the stage; wraps naturally.
  always_comb begin
    if (trailer_xfer_s) begin
      pkt_count_nx = pkt_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pkt_count_nx = pkt_count_r;
    end
  end

  // State, accumulator, output register and counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_DATA;
      sum_r       <= CHECKSUM_INIT;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      data_r      <= 8'h00;
      pkt_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nx;
      sum_r       <= sum_nx;
      valid_r     <= valid_nx;
      last_r      <= last_nx;
      data_r      <= data_nx;
      pkt_count_r <= pkt_count_nx;
    end
  end

endmodule

// File: tb/tb_stream_checksum_append.sv
// Directed scoreboard bench: drivers push expected beats, negedge monitors pop and compare.
module tb_stream_checksum_append;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  stream_checksum_append_if sk1 ();
  stream_checksum_append_if src1 ();
  stream_checksum_append_if sk2 ();
  stream_checksum_append_if src2 ();

  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  logic       drv_valid = 1'b0;
  logic       drv_last  = 1'b0;
  logic [7:0] drv_data  = 8'h00;
  logic       dsel      = 1'b0;
  logic       rdy1      = 1'b1;
  logic       rdy2      = 1'b1;
  bit         rmode     = 1'b0;
  logic [15:0] rpat     = 16'b1001_0110_1100_1010;

  assign sk1.valid  = drv_valid && !dsel;
  assign sk1.last   = drv_last;
  assign sk1.data   = drv_data;
  assign src1.ready = rdy1;
  assign sk2.valid  = drv_valid && dsel;
  assign sk2.last   = drv_last;
  assign sk2.data   = drv_data;
  assign src2.ready = rdy2;

  stream_checksum_append #(.CHECKSUM_INIT(8'h00), .CNT_WIDTH(16)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sink(sk1), .source(src1), .pkt_count(cnt1)
  );
  stream_checksum_append #(.CHECKSUM_INIT(8'h5A), .CNT_WIDTH(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sink(sk2), .source(src2), .pkt_count(cnt2)
  );

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int beats1 = 0;
  int last_beat_cyc = 0;
  int first_acc_cyc = -1;
  bit stall1 = 1'b0;
  logic [8:0] stall_word = 9'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Downstream ready pattern: constant high, or a rotating stall pattern.
  always @(posedge sys_clk) begin
    #1;
    if (rmode) begin
      rdy1 = rpat[15];
      rpat = {rpat[14:0], rpat[15]};
    end else begin
      rdy1 = 1'b1;
    end
  end

  // Monitors: hold stability, stall gating, and scoreboard pops.
  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (sys_rst) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) begin
        chk("hold_valid", {31'd0, src1.valid}, 32'd1);
        chk("hold_beat", {23'd0, src1.last, src1.data}, {23'd0, stall_word});
      end
      if (src1.valid && !src1.ready) chk("stall_sink_ready", {31'd0, sk1.ready}, 32'd0);
      stall1     = src1.valid && !src1.ready;
      stall_word = {src1.last, src1.data};
      if (src1.valid && src1.ready) begin
        beats1++;
        last_beat_cyc = cyc;
        if (q1.size() == 0) chk("dut1_unexpected_beat", {23'd0, src1.last, src1.data}, 32'h1FF);
        else begin
          e = q1.pop_front();
          chk("dut1_beat", {23'd0, src1.last, src1.data}, {23'd0, e});
        end
      end
      if (src2.valid && src2.ready) begin
        if (q2.size() == 0) chk("dut2_unexpected_beat", {23'd0, src2.last, src2.data}, 32'h1FF);
        else begin
          e = q2.pop_front();
          chk("dut2_beat", {23'd0, src2.last, src2.data}, {23'd0, e});
        end
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic l, input bit push);
    int  t;
    bit  ok;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_last  = l;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 64) begin
      @(negedge sys_clk);
      if (dsel ? sk2.ready : sk1.ready) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      chk("sink_accept_timeout", 32'd0, 32'd1);
    end else begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      if (push) begin
        if (dsel) q2.push_back({1'b0, d});
        else      q1.push_back({1'b0, d});
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] b[4], input int len, input logic [7:0] trailer,
                          input bit hold);
    for (int i = 0; i < len; i++) beat(b[i], (i == len - 1), 1'b1);
    if (dsel) q2.push_back({1'b1, trailer});
    else      q1.push_back({1'b1, trailer});
    if (!hold) drv_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    chk("drain_q1_empty", q1.size(), 32'd0);
    chk("drain_q2_empty", q2.size(), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_valid", {31'd0, src1.valid}, 32'd0);
    chk("rst_last", {31'd0, src1.last}, 32'd0);
    chk("rst_data", {24'd0, src1.data}, 32'd0);
    chk("rst_cnt", {16'd0, cnt1}, 32'd0);
    chk("rst_sink_ready", {31'd0, sk1.ready}, 32'd1);
    #23;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // Single packet with one bubble cycle after the last byte.
    send_pkt('{8'h01, 8'h02, 8'h03, 8'h00}, 3, 8'hFA, 1'b0);
    @(negedge sys_clk);
    chk("bubble_ready_low", {31'd0, sk1.ready}, 32'd0);
    @(negedge sys_clk);
    chk("bubble_ready_high", {31'd0, sk1.ready}, 32'd1);
    drain();
    chk("cnt_after_p1", {16'd0, cnt1}, 32'd1);

    // Modular wrap of the accumulator, then a single-byte zero packet.
    send_pkt('{8'hFF, 8'hFF, 8'h03, 8'h00}, 3, 8'hFF, 1'b0);
    send_pkt('{8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h00, 1'b0);
    drain();
    chk("cnt_after_wrap", {16'd0, cnt1}, 32'd3);

    // Backpressure with a stall pattern on downstream ready.
    rmode = 1'b1;
    send_pkt('{8'h10, 8'h11, 8'h12, 8'h13}, 4, 8'hBA, 1'b0);
    drain();
    rmode = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("cnt_after_bp", {16'd0, cnt1}, 32'd4);

    // Three back-to-back packets with sink valid held high.
    first_acc_cyc = -1;
    begin
      int b0;
      b0 = beats1;
      send_pkt('{8'h01, 8'h02, 8'h00, 8'h00}, 2, 8'hFD, 1'b1);
      send_pkt('{8'h01, 8'h02, 8'h00, 8'h00}, 2, 8'hFD, 1'b1);
      send_pkt('{8'h01, 8'h02, 8'h00, 8'h00}, 2, 8'hFD, 1'b0);
      drain();
      chk("b2b_beats", beats1 - b0, 32'd9);
      chk("b2b_span", last_beat_cyc - first_acc_cyc, 32'd9);
    end
    chk("cnt_after_b2b", {16'd0, cnt1}, 32'd7);

    // Reset in the middle of a packet discards it.
    beat(8'hAA, 1'b0, 1'b1);
    beat(8'hBB, 1'b0, 1'b0);
    drv_valid = 1'b0;
    sys_rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, src1.valid}, 32'd0);
    chk("midrst_data", {24'd0, src1.data}, 32'd0);
    chk("midrst_cnt", {16'd0, cnt1}, 32'd0);
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_sink_ready", {31'd0, sk1.ready}, 32'd1);
    @(posedge sys_clk);
    #1;
    send_pkt('{8'h05, 8'h00, 8'h00, 8'h00}, 1, 8'hFB, 1'b0);
    drain();
    chk("cnt_after_rst", {16'd0, cnt1}, 32'd1);

    // Non-zero initial accumulator and narrow wrapping counter.
    dsel = 1'b1;
    for (int p = 0; p < 5; p++) send_pkt('{8'h06, 8'h00, 8'h00, 8'h00}, 1, 8'hA0, 1'b0);
    drain();
    chk("cnt2_wrap", {30'd0, cnt2}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
